codec_sequencer: RTL and testbench

Frame-level controller for the RS/row codec datapath. Accepts 64-bit user words over a valid/ready handshake and drives the encoder with each word. It launches transmission of the 128-bit encoded message and waits for completion, bounded by a timeout. It then scans the decoder row by row, collecting per-row error positions, and presents one result per frame. It sits between the upstream data source and the encoder, transmission and decoder instances, replacing the free-running wiring in the top level.

---
 rtl/codec_sequencer.sv | 125 ++++++++++++
 tb/tb_codec_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_sequencer.sv
// codec_sequencer: frame-level controller for the RS/row codec datapath.
// Accepts one 64-bit word, encodes it, launches transmission, waits for
// completion (bounded by a timeout), then scans the decoder one row per
// cycle and presents a single result per frame.
module codec_sequencer #(
  parameter int ROWS       = 16,
  parameter int TX_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  output logic [63:0]  enc_data,
  input  logic [127:0] enc_message,
  output logic         tx_start,
  output logic [127:0] tx_message,
  input  logic         tx_done,
  input  logic [127:0] rx_message,
  output logic [127:0] dec_message,
  output logic [3:0]   dec_row,
  input  logic [7:0]   dec_err_pos,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_message,
  output logic [15:0]  out_err_mask,
  output logic [4:0]   out_err_count,
  output logic         out_timeout
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ENCODE   = 3'd1;
  localparam logic [2:0] TX_START = 3'd2;
  localparam logic [2:0] TX_WAIT  = 3'd3;
  localparam logic [2:0] DECODE   = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TX_TIMEOUT - 1);

  logic [2:0] state;
  logic [7:0] wait_cnt;

  // Ready only in IDLE and never while reset is held; independent of in_valid.
  assign in_ready = rst && (state == IDLE);

  // Frame sequencing: the mask and count registers double as the per-frame
  // accumulators during DECODE, so the result is complete on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      enc_data      <= 64'd0;
      tx_start      <= 1'b0;
      tx_message    <= 128'd0;
      dec_message   <= 128'd0;
      dec_row       <= 4'd0;
      out_valid     <= 1'b0;
      out_message   <= 128'd0;
      out_err_mask  <= 16'd0;
      out_err_count <= 5'd0;
      out_timeout   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            enc_data <= in_data;
            state    <= ENCODE;
          end
        end
        ENCODE: begin
          tx_message <= enc_message;
          tx_start   <= 1'b1;
          state      <= TX_START;
        end
        TX_START: begin
          wait_cnt <= 8'd0;
          state    <= TX_WAIT;
        end
        TX_WAIT: begin
          // Completion takes priority over a timeout on the same edge.
          if (tx_done) begin
            dec_message   <= rx_message;
            dec_row       <= 4'd0;
            out_err_mask  <= 16'd0;
            out_err_count <= 5'd0;
            out_timeout   <= 1'b0;
            state         <= DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            out_timeout   <= 1'b1;
            out_err_mask  <= 16'd0;
            out_err_count <= 5'd0;
            out_message   <= tx_message;
            out_valid     <= 1'b1;
            state         <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DECODE: begin
          if (dec_err_pos != 8'hFF) begin
            out_err_mask[dec_row] <= 1'b1;
            out_err_count         <= out_err_count + 5'd1;
          end
          if (dec_row == LAST_ROW) begin
            out_message <= dec_message;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            dec_row <= dec_row + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_sequencer.sv
// Directed testbench for codec_sequencer: one task per scenario, inline checks.
module tb_codec_sequencer;

  localparam logic [63:0]  D1   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0]  D2   = 64'h1111_2222_3333_4444;
  localparam logic [63:0]  D3   = 64'hFEDC_BA98_7654_3210;
  // Encoder stand-in: {data ^ A5A5A5A55A5A5A5A, data}, values worked by hand.
  localparam logic [127:0] EXP1 = 128'hA486E0C2_D3F197B5_01234567_89ABCDEF;
  localparam logic [127:0] EXP3 = 128'h5B791F3D_2C0E684A_FEDCBA98_76543210;
  localparam logic [127:0] RX1  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] RX2  = 128'h0F0F_0F0F_F0F0_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [127:0] RX3  = 128'hCAFE_F00D_8765_4321_0000_0000_FFFF_0001;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready;
  logic [63:0]  in_data, enc_data;
  logic [127:0] enc_message, tx_message, rx_message, dec_message, out_message;
  logic         tx_start, tx_done;
  logic [3:0]   dec_row;
  logic [7:0]   dec_err_pos;
  logic         out_valid, out_ready, out_timeout;
  logic [15:0]  out_err_mask, err_rows;
  logic [4:0]   out_err_count;

  logic         b_in_valid, b_in_ready;
  logic [63:0]  b_in_data, b_enc_data;
  logic [127:0] b_enc_message, b_tx_message, b_rx_message, b_dec_message, b_out_message;
  logic         b_tx_start, b_tx_done;
  logic [3:0]   b_dec_row, b_row_max;
  logic [7:0]   b_dec_err_pos;
  logic         b_out_valid, b_out_ready, b_out_timeout;
  logic [15:0]  b_out_err_mask, b_err_rows;
  logic [4:0]   b_out_err_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int tx_start_cnt = 0;

  assign enc_message   = {enc_data ^ 64'hA5A5_A5A5_5A5A_5A5A, enc_data};
  assign dec_err_pos   = err_rows[dec_row] ? 8'h05 : 8'hFF;
  assign b_enc_message = {b_enc_data ^ 64'hA5A5_A5A5_5A5A_5A5A, b_enc_data};
  assign b_dec_err_pos = b_err_rows[b_dec_row] ? 8'h05 : 8'hFF;

  codec_sequencer #(.ROWS(16), .TX_TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .enc_data(enc_data), .enc_message(enc_message), .tx_start(tx_start),
    .tx_message(tx_message), .tx_done(tx_done), .rx_message(rx_message),
    .dec_message(dec_message), .dec_row(dec_row), .dec_err_pos(dec_err_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_message(out_message),
    .out_err_mask(out_err_mask), .out_err_count(out_err_count), .out_timeout(out_timeout)
  );

  codec_sequencer #(.ROWS(2), .TX_TIMEOUT(255)) u_dut_rows2 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .enc_data(b_enc_data), .enc_message(b_enc_message), .tx_start(b_tx_start),
    .tx_message(b_tx_message), .tx_done(b_tx_done), .rx_message(b_rx_message),
    .dec_message(b_dec_message), .dec_row(b_dec_row), .dec_err_pos(b_dec_err_pos),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_message(b_out_message),
    .out_err_mask(b_out_err_mask), .out_err_count(b_out_err_count), .out_timeout(b_out_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count launch pulses and track the highest row used by the 2-row build.
  always @(negedge clk) begin
    if (tx_start === 1'b1) tx_start_cnt++;
    if (b_dec_row > b_row_max) b_row_max = b_dec_row;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept_word(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Edge e counts from the accepting edge E0; TX_WAIT edge n is E(n+2).
  task automatic finish_frame(input int done_at, input int first_e, output int lat);
    lat = -1;
    for (int e = first_e; e <= 400; e++) begin
      tx_done = (done_at > 0) && (e == done_at + 2);
      tick();
      tx_done = 1'b0;
      if (out_valid) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else pass_cnt++;
    total_cnt++; if (enc_data !== 64'd0) $display("FAIL reset_enc_data: got %h want 0", enc_data); else pass_cnt++;
    total_cnt++; if (out_message !== 128'd0) $display("FAIL reset_out_message: got %h want 0", out_message); else pass_cnt++;
    total_cnt++; if (out_err_count !== 5'd0) $display("FAIL reset_err_count: got %0d want 0", out_err_count); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready); else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic test_basic();
    int lat;
    int s0;
    s0 = tx_start_cnt;
    err_rows   = 16'h0000;
    rx_message = RX1;
    accept_word(D1);
    total_cnt++; if (enc_data !== D1) $display("FAIL basic_enc_data: got %h want %h", enc_data, D1); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_busy_ready: got %b want 0", in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (tx_start !== 1'b1) $display("FAIL basic_tx_start_high: got %b want 1", tx_start); else pass_cnt++;
    total_cnt++; if (tx_message !== EXP1) $display("FAIL basic_tx_message: got %h want %h", tx_message, EXP1); else pass_cnt++;
    tick();
    total_cnt++; if (tx_start !== 1'b0) $display("FAIL basic_tx_start_low: got %b want 0", tx_start); else pass_cnt++;
    finish_frame(1, 3, lat);
    total_cnt++; if (lat !== 19) $display("FAIL basic_latency: got %0d want 19", lat); else pass_cnt++;
    total_cnt++; if (out_err_mask !== 16'h0000) $display("FAIL basic_mask: got %h want 0000", out_err_mask); else pass_cnt++;
    total_cnt++; if (out_err_count !== 5'd0) $display("FAIL basic_count: got %0d want 0", out_err_count); else pass_cnt++;
    total_cnt++; if (out_timeout !== 1'b0) $display("FAIL basic_timeout: got %b want 0", out_timeout); else pass_cnt++;
    total_cnt++; if (out_message !== RX1) $display("FAIL basic_message: got %h want %h", out_message, RX1); else pass_cnt++;
    total_cnt++; if (tx_start_cnt - s0 !== 1) $display("FAIL basic_pulses: got %0d want 1", tx_start_cnt - s0); else pass_cnt++;
    release_result();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_ready_back: got %b want 1", in_ready); else pass_cnt++;
    $display("basic frame: latency=%0d mask=%h", lat, out_err_mask);
  endtask

  task automatic test_errors();
    int lat;
    err_rows   = 16'h8008;
    rx_message = RX2;
    accept_word(D2);
    finish_frame(1, 1, lat);
    total_cnt++; if (lat !== 19) $display("FAIL err_latency: got %0d want 19", lat); else pass_cnt++;
    total_cnt++; if (out_err_mask !== 16'h8008) $display("FAIL err_mask: got %h want 8008", out_err_mask); else pass_cnt++;
    total_cnt++; if (out_err_count !== 5'd2) $display("FAIL err_count: got %0d want 2", out_err_count); else pass_cnt++;
    total_cnt++; if (out_message !== RX2) $display("FAIL err_message: got %h want %h", out_message, RX2); else pass_cnt++;
    release_result();
    err_rows = 16'h0000;
    $display("error frame: mask=%h count=%0d", out_err_mask, out_err_count);
  endtask

  task automatic test_timeout();
    int lat;
    int s0;
    s0 = tx_start_cnt;
    err_rows   = 16'hFFFF;
    rx_message = RX3;
    accept_word(D3);
    finish_frame(0, 1, lat);
    total_cnt++; if (lat !== 6) $display("FAIL to_latency: got %0d want 6", lat); else pass_cnt++;
    total_cnt++; if (out_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", out_timeout); else pass_cnt++;
    total_cnt++; if (out_err_mask !== 16'h0000) $display("FAIL to_mask: got %h want 0000", out_err_mask); else pass_cnt++;
    total_cnt++; if (out_err_count !== 5'd0) $display("FAIL to_count: got %0d want 0", out_err_count); else pass_cnt++;
    total_cnt++; if (out_message !== EXP3) $display("FAIL to_message: got %h want %h", out_message, EXP3); else pass_cnt++;
    total_cnt++; if (tx_start_cnt - s0 !== 1) $display("FAIL to_pulses: got %0d want 1", tx_start_cnt - s0); else pass_cnt++;
    release_result();
    $display("timeout frame: latency=%0d timeout=%b", lat, out_timeout);
    // Completion on the last permitted edge beats the timeout.
    accept_word(D1);
    finish_frame(4, 1, lat);
    total_cnt++; if (lat !== 22) $display("FAIL late_latency: got %0d want 22", lat); else pass_cnt++;
    total_cnt++; if (out_timeout !== 1'b0) $display("FAIL late_flag: got %b want 0", out_timeout); else pass_cnt++;
    total_cnt++; if (out_message !== RX3) $display("FAIL late_message: got %h want %h", out_message, RX3); else pass_cnt++;
    total_cnt++; if (out_err_mask !== 16'hFFFF) $display("FAIL late_mask: got %h want ffff", out_err_mask); else pass_cnt++;
    total_cnt++; if (out_err_count !== 5'd16) $display("FAIL late_count: got %0d want 16", out_err_count); else pass_cnt++;
    release_result();
    err_rows = 16'h0000;
    $display("late tx_done frame: latency=%0d count=%0d", lat, out_err_count);
  endtask

  task automatic test_back_to_back();
    int lat;
    rx_message = RX1;
    accept_word(D1);
    finish_frame(1, 1, lat);
    in_valid = 1'b1;
    in_data  = D2;
    for (int i = 0; i < 10; i++) begin
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_message !== RX1) $display("FAIL bp_message[%0d]: got %h want %h", i, out_message, RX1); else pass_cnt++;
      tick();
    end
    release_result();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (enc_data !== D1) $display("FAIL bp_no_early_accept: got %h want %h", enc_data, D1); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_idle: got %b want 1", in_ready); else pass_cnt++;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (enc_data !== D2) $display("FAIL bp_second_accept: got %h want %h", enc_data, D2); else pass_cnt++;
    finish_frame(1, 1, lat);
    total_cnt++; if (lat !== 19) $display("FAIL bp_second_latency: got %0d want 19", lat); else pass_cnt++;
    release_result();
    $display("back-to-back: second frame latency=%0d", lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    rx_message = RX1;
    accept_word(D2);
    for (int e = 1; e <= 10; e++) begin
      tx_done = (e == 3);
      tick();
      tx_done = 1'b0;
    end
    total_cnt++; if (dec_row !== 4'd7) $display("FAIL rm_row: got %0d want 7", dec_row); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (dec_row !== 4'd0) $display("FAIL rm_dec_row: got %0d want 0", dec_row); else pass_cnt++;
    total_cnt++; if (enc_data !== 64'd0) $display("FAIL rm_enc_data: got %h want 0", enc_data); else pass_cnt++;
    total_cnt++; if (dec_message !== 128'd0) $display("FAIL rm_dec_message: got %h want 0", dec_message); else pass_cnt++;
    total_cnt++; if (out_message !== 128'd0) $display("FAIL rm_out_message: got %h want 0", out_message); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rm_ready_in_reset: got %b want 0", in_ready); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rm_ready_after: got %b want 1", in_ready); else pass_cnt++;
    accept_word(D1);
    finish_frame(1, 1, lat);
    total_cnt++; if (lat !== 19) $display("FAIL rm_new_latency: got %0d want 19", lat); else pass_cnt++;
    total_cnt++; if (out_message !== RX1) $display("FAIL rm_new_message: got %h want %h", out_message, RX1); else pass_cnt++;
    release_result();
    $display("reset mid-frame: recovery latency=%0d", lat);
  endtask

  task automatic test_rows2();
    int lat;
    b_err_rows   = 16'hFFFF;
    b_rx_message = RX2;
    b_row_max    = 4'd0;
    b_in_valid   = 1'b1;
    b_in_data    = D3;
    tick();
    b_in_valid = 1'b0;
    lat = -1;
    for (int e = 1; e <= 100; e++) begin
      b_tx_done = (e == 3);
      tick();
      b_tx_done = 1'b0;
      if (b_out_valid) begin
        lat = e;
        break;
      end
    end
    total_cnt++; if (lat !== 5) $display("FAIL r2_latency: got %0d want 5", lat); else pass_cnt++;
    total_cnt++; if (b_out_err_mask !== 16'h0003) $display("FAIL r2_mask: got %h want 0003", b_out_err_mask); else pass_cnt++;
    total_cnt++; if (b_out_err_count !== 5'd2) $display("FAIL r2_count: got %0d want 2", b_out_err_count); else pass_cnt++;
    total_cnt++; if (b_row_max !== 4'd1) $display("FAIL r2_row_max: got %0d want 1", b_row_max); else pass_cnt++;
    total_cnt++; if (b_out_message !== RX2) $display("FAIL r2_message: got %h want %h", b_out_message, RX2); else pass_cnt++;
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL r2_valid_drop: got %b want 0", b_out_valid); else pass_cnt++;
    $display("rows=2 frame: latency=%0d mask=%h", lat, b_out_err_mask);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_data = 64'd0; tx_done = 1'b0; rx_message = 128'd0;
    out_ready = 1'b0; err_rows = 16'd0;
    b_in_valid = 1'b0; b_in_data = 64'd0; b_tx_done = 1'b0; b_rx_message = 128'd0;
    b_out_ready = 1'b0; b_err_rows = 16'd0; b_row_max = 4'd0;
    test_reset();
    test_basic();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_rows2();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
